// File: rtl/rv_branch_pkg.sv
// Shared definitions for the RV32 branch prediction / target generation logic.
//  - Opcodes for conditional branches (B-type) and JAL.
//  - 2-bit saturating direction counter type and its four states.
package rv_branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Counter MSB is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strong not-taken
    CTR_WNT = 2'b01,  // weak not-taken
    CTR_WT  = 2'b10,  // weak taken
    CTR_ST  = 2'b11   // strong taken
  } ctr_t;

endpackage

// File: rtl/branch_imm_decode.sv
// Combinational immediate extraction for B-type and JAL instructions.
// Ports:
//  opcode    in  7     instruction[6:0]
//  inst      in  25    instruction[31:7]; instruction bit k = inst[k-7]
//  is_branch out 1     opcode is a conditional branch
//  is_jal    out 1     opcode is JAL
//  imm       out XLEN  sign-extended PC-relative offset (0 for other opcodes)
module branch_imm_decode
  import rv_branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [24:0]     inst,
  output logic            is_branch,
  output logic            is_jal,
  output logic [XLEN-1:0] imm
);

  logic [12:0] b_imm;
  logic [20:0] j_imm;

  // Instruction bit k lives at inst[k-7].
  // B: {i[31], i[7], i[30:25], i[11:8], 0}
  assign b_imm = {inst[24], inst[0], inst[23:18], inst[4:1], 1'b0};
  // J: {i[31], i[19:12], i[20], i[30:21], 0}
  assign j_imm = {inst[24], inst[12:5], inst[13], inst[23:14], 1'b0};

  always_comb begin
    is_branch = (opcode == OPC_BRANCH);
    is_jal    = (opcode == OPC_JAL);
    imm       = '0;
    if (is_branch) begin
      imm = {{(XLEN-13){b_imm[12]}}, b_imm};
    end else if (is_jal) begin
      imm = {{(XLEN-21){j_imm[20]}}, j_imm};
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-stage direct-mapped BTB with 2-bit direction counters, plus the
// decode-stage PC-relative target generator for B-type and JAL.
// Ports:
//  clk, reset                    rising-edge clock, synchronous active-high reset
//  flush                         kills the lookup/decode results of this cycle
//  lookup_valid, lookup_pc       fetch lookup request
//  pred_valid/hit/taken/target   lookup result, one cycle later (target 0 on miss)
//  dec_valid/opcode/inst/pc      decode-stage instruction
//  tgt_valid/is_jal/addr         decoded branch/JAL target, one cycle later
//  upd_valid/pc/taken/target     EX-stage resolution used to train the table
module branch_target_buffer
  import rv_branch_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = XLEN - INDEX_W - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            dec_valid,
  input  logic [6:0]      dec_opcode,
  input  logic [24:0]     dec_inst,
  input  logic [XLEN-1:0] dec_pc,
  output logic            tgt_valid,
  output logic            tgt_is_jal,
  output logic [XLEN-1:0] tgt_addr,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  function automatic ctr_t ctr_sat_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
  endfunction

  function automatic ctr_t ctr_sat_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
  endfunction

  // Table storage
  logic [ENTRIES-1:0] tbl_valid;
  logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
  logic [XLEN-1:0]    tbl_target [ENTRIES];
  ctr_t               tbl_ctr    [ENTRIES];

  // Byte-offset bits of the PCs carry no information for aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup read (stage 0)
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_go;
  logic               lk_hit;

  assign lk_idx = lookup_pc[INDEX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:INDEX_W+2];
  assign lk_go  = lookup_valid & ~flush;
  assign lk_hit = lk_go & tbl_valid[lk_idx] & (tbl_tag[lk_idx] == lk_tag);

  // Lookup result register (stage 0 -> 1)
  logic            vld_p1;
  logic            hit_p1;
  logic            taken_p1;
  logic [XLEN-1:0] target_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      hit_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
    end else begin
      vld_p1    <= lk_go;
      hit_p1    <= lk_hit;
      taken_p1  <= lk_hit & tbl_ctr[lk_idx][1];
      target_p1 <= lk_hit ? tbl_target[lk_idx] : '0;
    end
  end

  assign pred_valid  = vld_p1;
  assign pred_hit    = hit_p1;
  assign pred_taken  = taken_p1;
  assign pred_target = target_p1;

  // Decode target generation (stage 0)
  logic            dec_is_branch;
  logic            dec_is_jal;
  logic [XLEN-1:0] dec_imm;
  logic            dec_go;

  branch_imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .opcode    (dec_opcode),
    .inst      (dec_inst),
    .is_branch (dec_is_branch),
    .is_jal    (dec_is_jal),
    .imm       (dec_imm)
  );

  assign dec_go = dec_valid & ~flush & (dec_is_branch | dec_is_jal);

  // Decode result register (stage 0 -> 1); the add wraps modulo 2^XLEN.
  logic            tgt_vld_p1;
  logic            tgt_jal_p1;
  logic [XLEN-1:0] tgt_addr_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_vld_p1  <= 1'b0;
      tgt_jal_p1  <= 1'b0;
      tgt_addr_p1 <= '0;
    end else begin
      tgt_vld_p1  <= dec_go;
      tgt_jal_p1  <= dec_go & dec_is_jal;
      tgt_addr_p1 <= dec_go ? (dec_pc + dec_imm) : '0;
    end
  end

  assign tgt_valid  = tgt_vld_p1;
  assign tgt_is_jal = tgt_jal_p1;
  assign tgt_addr   = tgt_addr_p1;

  // Table training. Writes land at the edge, so a same-cycle lookup above
  // still sees the old entry.
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;

  assign up_idx = upd_pc[INDEX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:INDEX_W+2];
  assign up_hit = tbl_valid[up_idx] & (tbl_tag[up_idx] == up_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_valid <= '0;
    end else if (upd_valid && !up_hit && upd_taken) begin
      tbl_valid[up_idx] <= 1'b1;
    end
  end

  // Entry payload is not cleared by reset (valid bits gate it), but a
  // concurrent update must not land while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          tbl_ctr[up_idx]    <= ctr_sat_inc(tbl_ctr[up_idx]);
          tbl_target[up_idx] <= upd_target;
        end else begin
          tbl_ctr[up_idx]    <= ctr_sat_dec(tbl_ctr[up_idx]);
        end
      end else if (upd_taken) begin
        tbl_tag[up_idx]    <= up_tag;
        tbl_target[up_idx] <= upd_target;
        tbl_ctr[up_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (XLEN=32, ENTRIES=16).
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        dec_valid;
  logic [6:0]  dec_opcode;
  logic [24:0] dec_inst;
  logic [31:0] dec_pc;
  logic        tgt_valid;
  logic        tgt_is_jal;
  logic [31:0] tgt_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int checks = 0;
  int errors = 0;

  branch_target_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .dec_valid    (dec_valid),
    .dec_opcode   (dec_opcode),
    .dec_inst     (dec_inst),
    .dec_pc       (dec_pc),
    .tgt_valid    (tgt_valid),
    .tgt_is_jal   (tgt_is_jal),
    .tgt_addr     (tgt_addr),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic do_dec(input logic [31:0] pc, input logic [31:0] inst);
    dec_valid = 1'b1; dec_pc = pc; dec_opcode = inst[6:0]; dec_inst = inst[31:7];
    step();
    dec_valid = 1'b0;
  endtask

  task automatic chk_pred(input string tag, input logic hit, input logic taken, input logic [31:0] tgt);
    chk({tag, "_valid"},  {31'd0, pred_valid}, 32'd1);
    chk({tag, "_hit"},    {31'd0, pred_hit},   {31'd0, hit});
    chk({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, taken});
    chk({tag, "_target"}, pred_target,         tgt);
  endtask

  task automatic chk_tgt(input string tag, input logic vld, input logic jal, input logic [31:0] addr);
    chk({tag, "_valid"}, {31'd0, tgt_valid},  {31'd0, vld});
    chk({tag, "_jal"},   {31'd0, tgt_is_jal}, {31'd0, jal});
    chk({tag, "_addr"},  tgt_addr,            addr);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0;
    dec_valid = 1'b0; dec_opcode = '0; dec_inst = '0; dec_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    step(); step();
    chk("rst_pred_valid",  {31'd0, pred_valid}, 32'd0);
    chk("rst_pred_hit",    {31'd0, pred_hit},   32'd0);
    chk("rst_pred_target", pred_target,         32'd0);
    chk("rst_tgt_valid",   {31'd0, tgt_valid},  32'd0);
    chk("rst_tgt_addr",    tgt_addr,            32'd0);
    reset = 1'b0;

    // Cold lookup misses
    do_lookup(32'h100);
    chk_pred("cold", 1'b0, 1'b0, 32'h0);

    // Allocate, then train the counter through both saturation points
    do_upd(32'h100, 1'b1, 32'h80);          // alloc, 10
    do_lookup(32'h100);
    chk_pred("alloc", 1'b1, 1'b1, 32'h80);
    do_upd(32'h100, 1'b0, 32'h0);           // 01
    do_lookup(32'h100);
    chk_pred("nt1", 1'b1, 1'b0, 32'h80);
    do_upd(32'h100, 1'b0, 32'h0);           // 00
    do_upd(32'h100, 1'b0, 32'h0);           // stays 00
    do_lookup(32'h100);
    chk_pred("satlo", 1'b1, 1'b0, 32'h80);
    do_upd(32'h100, 1'b1, 32'h90);          // 01, target replaced
    do_lookup(32'h100);
    chk_pred("tgtupd", 1'b1, 1'b0, 32'h90);
    do_upd(32'h100, 1'b1, 32'h90);          // 10
    do_upd(32'h100, 1'b1, 32'h90);          // 11
    do_upd(32'h100, 1'b1, 32'h90);          // stays 11
    do_upd(32'h100, 1'b0, 32'h0);           // 10
    do_lookup(32'h100);
    chk_pred("sathi", 1'b1, 1'b1, 32'h90);

    // Aliasing on index 0
    do_lookup(32'h140);
    chk_pred("alias_miss", 1'b0, 1'b0, 32'h0);
    do_upd(32'h140, 1'b1, 32'h300);
    do_lookup(32'h100);
    chk_pred("evicted", 1'b0, 1'b0, 32'h0);
    do_lookup(32'h142);                     // low bits ignored
    chk_pred("replaced", 1'b1, 1'b1, 32'h300);
    do_upd(32'h500, 1'b0, 32'h0);           // miss & not-taken: no allocate
    do_lookup(32'h500);
    chk_pred("nt_noalloc", 1'b0, 1'b0, 32'h0);

    // Decode targets
    do_dec(32'h200, 32'hFE000CE3);          // BEQ -8
    chk_tgt("beq", 1'b1, 1'b0, 32'h1F8);
    do_dec(32'h1000, 32'h00001863);         // BNE +16
    chk_tgt("bne", 1'b1, 1'b0, 32'h1010);
    do_dec(32'hFFFFFFFC, 32'h0080006F);     // JAL +8, wraps
    chk_tgt("jal_wrap", 1'b1, 1'b1, 32'h4);
    do_dec(32'h2000, 32'hFFDFF06F);         // JAL -4
    chk_tgt("jal_neg", 1'b1, 1'b1, 32'h1FFC);
    do_dec(32'h300, 32'h00100093);          // ADDI
    chk_tgt("addi", 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and allocate from empty
    reset = 1'b1; step(); reset = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    do_upd(32'h100, 1'b1, 32'h80);
    lookup_valid = 1'b0;
    chk_pred("samecyc", 1'b0, 1'b0, 32'h0);
    do_lookup(32'h100);
    chk_pred("after_same", 1'b1, 1'b1, 32'h80);
    do_upd(32'h100, 1'b0, 32'h0);           // 10 -> 01
    do_lookup(32'h100);
    chk_pred("was_wt", 1'b1, 1'b0, 32'h80);

    // Flush kills both results but keeps the table
    flush = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    do_dec(32'h200, 32'hFE000CE3);
    flush = 1'b0; lookup_valid = 1'b0;
    chk("flush_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("flush_pred_hit",   {31'd0, pred_hit},   32'd0);
    chk("flush_tgt_valid",  {31'd0, tgt_valid},  32'd0);
    chk("flush_tgt_addr",   tgt_addr,            32'd0);
    do_lookup(32'h100);
    chk_pred("postflush", 1'b1, 1'b0, 32'h80);

    // Reset mid-training wins over a concurrent update and lookup
    do_upd(32'h200, 1'b1, 32'h44);
    reset = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h200;
    do_upd(32'h300, 1'b1, 32'h55);
    reset = 1'b0; lookup_valid = 1'b0;
    chk("rst_mid_valid", {31'd0, pred_valid}, 32'd0);
    do_lookup(32'h100);
    chk_pred("rst_100", 1'b0, 1'b0, 32'h0);
    do_lookup(32'h200);
    chk_pred("rst_200", 1'b0, 1'b0, 32'h0);
    do_lookup(32'h300);
    chk_pred("rst_300", 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
